// File: rtl/ysyx_22040127_mem_stage_if.sv
//==============================================================================
// Module   : ysyx_22040127_mem_stage_if
// Purpose  : EX->MEM, data-memory and MEM->WB signal bundle of the MEM stage.
//            mem_misalign exists only when MEM_MISALIGN_CHECK_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ysyx_22040127_mem_stage_if #(
  parameter int CSRP_W = 90
);
  logic                  ex_to_mem_valid;
  logic                  mem_allowin;
  logic [31:0]           ex_pc;
  logic [4:0]            ex_rd;
  logic                  ex_reg_wen;
  logic [63:0]           ex_alu_result;
  logic [63:0]           ex_store_data;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [1:0]            ex_mem_size;
  logic                  ex_load_unsigned;
  logic [CSRP_W-1:0]     ex_csr_pass;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [63:0]           dmem_addr;
  logic [63:0]           dmem_wdata;
  logic [7:0]            dmem_wmask;
  logic                  dmem_ack;
  logic [63:0]           dmem_rdata;

  logic                  mem_flush;
  logic                  wb_allowin;
  logic                  mem_to_wb_valid;
  logic [230+CSRP_W:0]   mem_to_wb_bus;

  logic                  mem_fwd_valid;
  logic                  mem_fwd_ready;
  logic [4:0]            mem_fwd_rd;
  logic [63:0]           mem_fwd_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                  mem_misalign;
`endif

  // MEM stage side
  modport slave (
`ifdef MEM_MISALIGN_CHECK_EN
    output mem_misalign,
`endif
    input  ex_to_mem_valid, ex_pc, ex_rd, ex_reg_wen, ex_alu_result, ex_store_data,
    input  ex_mem_read, ex_mem_write, ex_mem_size, ex_load_unsigned, ex_csr_pass,
    input  dmem_ack, dmem_rdata, mem_flush, wb_allowin,
    output mem_allowin, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output mem_to_wb_valid, mem_to_wb_bus,
    output mem_fwd_valid, mem_fwd_ready, mem_fwd_rd, mem_fwd_data
  );

  // EX / memory / WB side
  modport master (
`ifdef MEM_MISALIGN_CHECK_EN
    input  mem_misalign,
`endif
    output ex_to_mem_valid, ex_pc, ex_rd, ex_reg_wen, ex_alu_result, ex_store_data,
    output ex_mem_read, ex_mem_write, ex_mem_size, ex_load_unsigned, ex_csr_pass,
    output dmem_ack, dmem_rdata, mem_flush, wb_allowin,
    input  mem_allowin, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  mem_to_wb_valid, mem_to_wb_bus,
    input  mem_fwd_valid, mem_fwd_ready, mem_fwd_rd, mem_fwd_data
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22040127_mem_stage.sv
//==============================================================================
// Module   : ysyx_22040127_mem_stage
// Purpose  : MEM pipeline stage: req/ack data-memory access, store lane
//            alignment, load extension and MEM->WB handoff with forwarding view.
//            Optional macro MEM_MISALIGN_CHECK_EN traps misaligned accesses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_22040127_mem_stage #(
  parameter int CSRP_W = 90
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_22040127_mem_stage_if.slave        mem_if
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_BUSY = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              killed_q, killed_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_wen_q, reg_wen_d;
  logic [63:0]       alu_q, alu_d;
  logic [63:0]       sdata_q, sdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CSRP_W-1:0] csr_q, csr_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              w_in_misalign;
  logic              w_misalign;
  logic              w_access;
  logic              w_ready_go;
  logic              w_to_wb_valid;
  logic              w_allowin;
  logic              w_load;
  logic              w_start;
  logic [5:0]        w_shift;
  logic [63:0]       w_rshift;
  logic [63:0]       w_load_val;
  logic [7:0]        w_mask_base;
  logic [63:0]       w_reg_wdata;
  logic [63:0]       w_diff_data;
  logic              w_reg_wen_out;
  logic              w_memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
  logic [2:0]        w_align_mask;

  always_comb begin
    case (mem_if.ex_mem_size)
      2'd0:    w_align_mask = 3'b000;
      2'd1:    w_align_mask = 3'b001;
      2'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_in_misalign = (mem_if.ex_mem_read || mem_if.ex_mem_write) &&
                         (|(mem_if.ex_alu_result[2:0] & w_align_mask));
  assign misalign_d    = w_load ? w_in_misalign : misalign_q;
  assign w_misalign    = misalign_q;
  assign mem_if.mem_misalign = w_to_wb_valid && mem_if.wb_allowin && misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign w_in_misalign = 1'b0;
  assign w_misalign    = 1'b0;
`endif

  // A misaligned access is retired like a plain ALU op, without touching memory.
  assign w_access      = (mem_read_q || mem_write_q) && !w_misalign;
  assign w_ready_go    = !w_access || (state_q == C_DONE);
  assign w_to_wb_valid = mem_valid_q && !killed_q && w_ready_go;
  assign w_allowin     = !rst && (!mem_valid_q || (w_ready_go && mem_if.wb_allowin) ||
                                  (killed_q && (state_q != C_BUSY)));
  assign w_load        = mem_if.ex_to_mem_valid && w_allowin;
  assign w_start       = w_load && !mem_if.mem_flush &&
                         (mem_if.ex_mem_read || mem_if.ex_mem_write) && !w_in_misalign;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    killed_d    = 1'b0;
    case (state_q)
      C_IDLE:  state_d = w_start ? C_BUSY : C_IDLE;
      C_BUSY:  state_d = mem_if.dmem_ack ? C_DONE : C_BUSY;
      C_DONE:  if (w_allowin || mem_if.mem_flush) state_d = w_start ? C_BUSY : C_IDLE;
      default: state_d = C_IDLE;
    endcase

    if (w_load)                                     mem_valid_d = !mem_if.mem_flush;
    else if (mem_if.mem_flush && state_q != C_BUSY) mem_valid_d = 1'b0;
    else if (w_allowin)                             mem_valid_d = 1'b0;

    // A squashed access must still finish its memory handshake before leaving.
    if (state_q == C_BUSY) killed_d = killed_q || (mem_if.mem_flush && mem_valid_q);
  end

  always_comb begin
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_wen_d   = reg_wen_q;
    alu_d       = alu_q;
    sdata_d     = sdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    csr_d       = csr_q;
    rdata_d     = rdata_q;
    if (w_load) begin
      pc_d        = mem_if.ex_pc;
      rd_d        = mem_if.ex_rd;
      reg_wen_d   = mem_if.ex_reg_wen;
      alu_d       = mem_if.ex_alu_result;
      sdata_d     = mem_if.ex_store_data;
      mem_read_d  = mem_if.ex_mem_read;
      mem_write_d = mem_if.ex_mem_write;
      size_d      = mem_if.ex_mem_size;
      uns_d       = mem_if.ex_load_unsigned;
      csr_d       = mem_if.ex_csr_pass;
    end
    if (state_q == C_BUSY && mem_if.dmem_ack) rdata_d = mem_if.dmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= C_IDLE;
      mem_valid_q <= 1'b0;
      killed_q    <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_wen_q   <= 1'b0;
      alu_q       <= '0;
      sdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      csr_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      killed_q    <= killed_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_wen_q   <= reg_wen_d;
      alu_q       <= alu_d;
      sdata_q     <= sdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      csr_q       <= csr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign w_shift  = {alu_q[2:0], 3'b000};
  assign w_rshift = rdata_q >> w_shift;

  always_comb begin
    case (size_q)
      2'd0: begin
        w_mask_base = 8'h01;
        w_load_val  = uns_q ? {56'd0, w_rshift[7:0]}  : {{56{w_rshift[7]}}, w_rshift[7:0]};
      end
      2'd1: begin
        w_mask_base = 8'h03;
        w_load_val  = uns_q ? {48'd0, w_rshift[15:0]} : {{48{w_rshift[15]}}, w_rshift[15:0]};
      end
      2'd2: begin
        w_mask_base = 8'h0F;
        w_load_val  = uns_q ? {32'd0, w_rshift[31:0]} : {{32{w_rshift[31]}}, w_rshift[31:0]};
      end
      default: begin
        w_mask_base = 8'hFF;
        w_load_val  = w_rshift;
      end
    endcase
  end

  assign w_reg_wdata   = mem_read_q ? w_load_val : alu_q;
  assign w_diff_data   = mem_write_q ? sdata_q : (mem_read_q ? w_load_val : 64'd0);
  assign w_reg_wen_out = reg_wen_q && !w_misalign;
  assign w_memwrite    = mem_write_q && !w_misalign;

  // Lanes pushed past byte 7 simply fall off the top of the mask and data.
  assign mem_if.dmem_req   = (state_q == C_BUSY);
  assign mem_if.dmem_we    = (state_q == C_BUSY) && mem_write_q;
  assign mem_if.dmem_addr  = {alu_q[63:3], 3'b000};
  assign mem_if.dmem_wmask = w_mask_base << alu_q[2:0];
  assign mem_if.dmem_wdata = sdata_q << w_shift;

  assign mem_if.mem_allowin     = w_allowin;
  assign mem_if.mem_to_wb_valid = w_to_wb_valid;
  assign mem_if.mem_to_wb_bus   = {w_memwrite, w_diff_data, alu_q, csr_q, pc_q,
                                   w_reg_wen_out, rd_q, w_reg_wdata};

  assign mem_if.mem_fwd_valid = mem_valid_q && !killed_q && w_reg_wen_out && (rd_q != 5'd0);
  assign mem_if.mem_fwd_ready = w_ready_go;
  assign mem_if.mem_fwd_rd    = rd_q;
  assign mem_if.mem_fwd_data  = w_reg_wdata;

endmodule

`default_nettype wire
